// File: rtl/seq_mag_comp.sv
// -----------------------------------------------------------------------------
// seq_mag_comp
//
// Iterative unsigned magnitude comparator. On an accepted start the two
// operands are captured, then compared one 2-bit slice per clock, most
// significant slice first. The first unequal slice settles the result
// immediately. If every slice is equal, the result is "equal" after the last
// slice. Each completed compare updates the registered e/l/g flags and
// pulses done for one cycle.
//
// Parameters
//   WIDTH  operand width in bits (even, >= 2); N = WIDTH/2 slices
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   compare request, only looked at while idle
//   a, b   in   operands, captured on the accepted start edge
//   busy   out  high while a compare is running or just completed
//   done   out  one-cycle pulse when e/l/g have just been written
//   e/l/g  out  registered result: a == b / a < b / a > b
// -----------------------------------------------------------------------------
module seq_mag_comp #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             e,
    output logic             l,
    output logic             g
);

    localparam int N  = WIDTH / 2;
    // The slice index always needs at least one bit, even when N == 1.
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             e_q, e_d;
    logic             l_q, l_d;
    logic             g_q, g_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [1:0]       sa_s;
    logic [1:0]       sb_s;

    // Select slice i of v. This uses constant part-selects only, so the
    // index width never has to match the operand's bit-index width.
    function automatic logic [1:0] slice_at(input logic [WIDTH-1:0] v,
                                            input logic [IW-1:0]    i);
        logic [1:0] r;
        r = 2'b00;
        for (int s = 0; s < N; s++) begin
            if (i == IW'(s)) begin
                r = v[2*s +: 2];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Current slice pair under evaluation.
    always_comb begin
        sa_s = slice_at(a_q, idx_q);
        sb_s = slice_at(b_q, idx_q);
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        e_d     = e_q;
        l_d     = l_q;
        g_d     = g_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IW'(N - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (sa_s > sb_s) begin
                    g_d     = 1'b1;
                    e_d     = 1'b0;
                    l_d     = 1'b0;
                    state_d = ST_DONE;
                end else if (sa_s < sb_s) begin
                    l_d     = 1'b1;
                    e_d     = 1'b0;
                    g_d     = 1'b0;
                    state_d = ST_DONE;
                end else if (idx_q == {IW{1'b0}}) begin
                    e_d     = 1'b1;
                    l_d     = 1'b0;
                    g_d     = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q - IW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // busy/done are registered alongside the state they describe.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, captured operands, slice index and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= {IW{1'b0}};
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            e_q     <= 1'b0;
            l_q     <= 1'b0;
            g_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            e_q     <= e_d;
            l_q     <= l_d;
            g_q     <= g_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign e    = e_q;
    assign l    = l_q;
    assign g    = g_q;

endmodule

// File: tb/tb_seq_mag_comp.sv
// -----------------------------------------------------------------------------
// tb_seq_mag_comp
//
// Scoreboard bench for seq_mag_comp at WIDTH=8 and WIDTH=2. The drivers push
// the expected {e,l,g} and the expected done edge for every accepted start.
// Independent monitors pop an entry and compare it whenever done is seen.
// The reference computes the result and the number of slices examined
// directly from the operand values.
// -----------------------------------------------------------------------------
module tb_seq_mag_comp;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, start2;
    logic [7:0] a8, b8;
    logic [1:0] a2, b2;
    logic       busy8, done8, e8, l8, g8;
    logic       busy2, done2, e2, l2, g2;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_bad  = 0;

    typedef struct {
        logic [2:0] elg;
        int         start_edge;
        int         k;
    } exp_t;

    exp_t q8[$];
    exp_t q2[$];

    logic prev_done8 = 1'b0;
    logic prev_done2 = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    seq_mag_comp #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .e(e8), .l(l8), .g(g8)
    );

    seq_mag_comp #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .e(e2), .l(l2), .g(g2)
    );

    // Reference result as {e,l,g}.
    function automatic logic [2:0] ref_elg(input int x, input int y);
        if (x == y) return 3'b100;
        else if (x < y) return 3'b010;
        else return 3'b001;
    endfunction

    // Number of slices examined: position of first differing 2-bit digit
    // counted from the top, or all digits when the operands are equal.
    function automatic int ref_k(input int x, input int y, input int w);
        for (int s = w/2 - 1; s >= 0; s--) begin
            if (((x >> (2*s)) % 4) != ((y >> (2*s)) % 4)) return w/2 - s;
        end
        return w/2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // WIDTH=8 monitor.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done8 <= 1'b0;
        end else begin
            if (prev_done8) check("w8_busy_after_done", {31'd0, busy8}, 32'd0);
            if (done8) begin
                check("w8_done_gap", {31'd0, prev_done8}, 32'd0);
                check("w8_busy_with_done", {31'd0, busy8}, 32'd1);
                if (q8.size() == 0) begin
                    check("w8_unexpected_done", q8.size(), 32'd1);
                end else begin
                    exp_t x;
                    x = q8.pop_front();
                    check("w8_elg", {29'd0, e8, l8, g8}, {29'd0, x.elg});
                    check("w8_latency", cyc - x.start_edge, x.k);
                end
            end
            prev_done8 <= done8;
        end
    end

    // WIDTH=2 monitor.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done2 <= 1'b0;
        end else begin
            if (prev_done2) check("w2_busy_after_done", {31'd0, busy2}, 32'd0);
            if (done2) begin
                check("w2_done_gap", {31'd0, prev_done2}, 32'd0);
                if (q2.size() == 0) begin
                    check("w2_unexpected_done", q2.size(), 32'd1);
                end else begin
                    exp_t x;
                    x = q2.pop_front();
                    check("w2_elg", {29'd0, e2, l2, g2}, {29'd0, x.elg});
                    check("w2_latency", cyc - x.start_edge, x.k);
                end
            end
            prev_done2 <= done2;
        end
    end

    task automatic drain(input string name);
        int t = 0;
        while ((q8.size() != 0 || q2.size() != 0) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check({name, "_timeout"}, q8.size() + q2.size(), 32'd0);
    endtask

    // One WIDTH=8 compare. Operands are scrambled after acceptance.
    task automatic go8(input logic [7:0] x, input logic [7:0] y);
        exp_t ex;
        @(negedge clk);
        a8 = x; b8 = y; start8 = 1'b1;
        ex.elg = ref_elg(int'(x), int'(y));
        ex.start_edge = cyc + 1;
        ex.k = ref_k(int'(x), int'(y), 8);
        q8.push_back(ex);
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        drain("go8");
    endtask

    task automatic go2(input logic [1:0] x, input logic [1:0] y);
        exp_t ex;
        @(negedge clk);
        a2 = x; b2 = y; start2 = 1'b1;
        ex.elg = ref_elg(int'(x), int'(y));
        ex.start_edge = cyc + 1;
        ex.k = 1;
        q2.push_back(ex);
        @(negedge clk);
        start2 = 1'b0;
        a2 = 2'($urandom); b2 = 2'($urandom);
        drain("go2");
    endtask

    initial begin
        int next_acc;
        int pushed;
        exp_t ex;

        rst_n = 1'b0; start8 = 1'b0; start2 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; a2 = 2'b00; b2 = 2'b00;
        #2;
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_done", {31'd0, done8}, 32'd0);
        check("rst_elg",  {29'd0, e8, l8, g8}, 32'd0);
        check("rst_w2_elg", {29'd0, busy2, done2, e2 | l2 | g2}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        go8(8'hA5, 8'hA5);
        go8(8'h80, 8'h7F);
        go8(8'h12, 8'h13);
        go8(8'h3C, 8'h34);

        // Start during RUN must be ignored.
        @(negedge clk);
        a8 = 8'h00; b8 = 8'h01; start8 = 1'b1;
        ex.elg = 3'b010; ex.start_edge = cyc + 1; ex.k = 4;
        q8.push_back(ex);
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        drain("ignored");
        repeat (6) @(negedge clk);
        check("ignored_hold", {29'd0, e8, l8, g8}, 32'd2);
        check("ignored_idle", {31'd0, busy8}, 32'd0);

        // Reset in the middle of a compare.
        @(negedge clk);
        a8 = 8'h11; b8 = 8'h11; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        q8.delete();
        #1;
        check("abort_busy", {31'd0, busy8}, 32'd0);
        check("abort_done", {31'd0, done8}, 32'd0);
        check("abort_elg",  {29'd0, e8, l8, g8}, 32'd0);
        repeat (3) @(negedge clk);
        check("abort_hold", {30'd0, busy8, done8}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        go8(8'h02, 8'h01);

        // Random single compares, biased towards shared upper slices.
        for (int i = 0; i < 20; i++) begin
            logic [7:0] x, y;
            x = 8'($urandom);
            y = (i % 2 == 0) ? (x ^ 8'($urandom_range(0, 3))) : 8'($urandom);
            go8(x, y);
        end

        // Back-to-back with start held high and fresh operands every cycle.
        @(negedge clk);
        next_acc = cyc + 1;
        pushed = 0;
        start8 = 1'b1;
        while (pushed < 30) begin
            a8 = 8'($urandom);
            b8 = (pushed % 3 == 0) ? a8 : 8'($urandom);
            if (cyc + 1 == next_acc) begin
                ex.elg = ref_elg(int'(a8), int'(b8));
                ex.start_edge = next_acc;
                ex.k = ref_k(int'(a8), int'(b8), 8);
                q8.push_back(ex);
                next_acc = next_acc + ex.k + 2;
                pushed++;
            end
            @(negedge clk);
        end
        start8 = 1'b0;
        drain("b2b");

        // WIDTH=2 exhaustive.
        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                go2(2'(x), 2'(y));
            end
        end

        repeat (4) @(negedge clk);
        check("q8_empty", q8.size(), 32'd0);
        check("q2_empty", q2.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
